layer4_argmax: RTL and testbench
================================

Name: layer4_argmax

Overview:
- Downstream consumer of the layer-4 fully-connected node outputs (N0x..N24x).
- Each node output is a 32-bit, ReLU-clamped, Q13-scaled value; only bits [15:0] can be non-zero.
- On a start pulse the block snapshots all node outputs, then scans them one per cycle.
- It reports the winning class index and its value to the classification result logic.

Parameters:
- NUM_IN, 25, number of node outputs scanned (N0x..N{NUM_IN-1}x).
- IDX_W, 5, width of the class index; must satisfy 2^IDX_W >= NUM_IN.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request to classify the current node outputs.
- Nx_flat  input  32*NUM_IN  packed node outputs; node i occupies bits [32*i+31:32*i].
- busy  output  1  high while a snapshot/scan is in progress.
- done  output  1  one-cycle pulse; result outputs valid from this cycle on.
- class_idx  output  IDX_W  index of the largest node output.
- max_val  output  32  value of the largest node output.
- all_zero  output  1  set with done when every scanned value was 0.

Behaviour:
- Reset (reset==0 sampled at a rising edge): state=IDLE; busy=0, done=0, class_idx=0, max_val=0, all_zero=0; counter, best registers and snapshot bank cleared. Reset overrides all other activity, including mid-scan.
- Comparison rules:
  - values compared as unsigned 32-bit;
  - strict greater-than, so on ties the lowest index wins;
  - upper bits are compared as-is (not masked).
- FSM IDLE:
  - start==1 at edge k: Nx_flat copied into snapshot bank snap[0..NUM_IN-1].
  - At the same edge: cnt=0, best_val=0, best_idx=0, busy=1, state=SCAN.
  - start==0: hold; all outputs keep their last values, done=0.
- FSM SCAN, edge k+1+j for j=0..NUM_IN-1:
  - cnt==j;
  - if snap[j] > best_val: best_val<=snap[j], best_idx<=j;
  - cnt increments.
- Last SCAN edge (cnt==NUM_IN-1):
  - the final compare result (including snap[NUM_IN-1]) is written directly to class_idx and max_val;
  - all_zero<=(final best value==0);
  - done<=1, busy<=0, state=IDLE.
- Latency and throughput:
  - done is high in the cycle following edge k+NUM_IN (NUM_IN edges after start is sampled; 25 for the default);
  - next start accepted at edge k+NUM_IN+1 at the earliest, so one result every NUM_IN+1 cycles.
- done is high for exactly one cycle. class_idx, max_val and all_zero hold until the next completed scan or reset.
- start while busy==1 is ignored: no restart, no queueing.
- start in the same cycle that done is high is accepted, because state is already IDLE.
- Nx_flat changes after the snapshot edge do not affect the result.
- Reset during SCAN: scan aborted, no done pulse, outputs return to reset values.

Test Plan:
1. Reset behaviour: hold reset=0 for 3 cycles with start=1 and random inputs -> busy=0, done=0, class_idx=0, max_val=0, all_zero=0 throughout. Release reset, idle 5 cycles -> no done pulse.
2. Single maximum: N7x=0x0000_1F00, all others <=0x0000_0100, pulse start at edge k -> done high only after edge k+25; class_idx=7, max_val=0x1F00, all_zero=0, busy high for edges k..k+24.
3. Tie and last-element case:
   - N3x=N20x=0x800, others 0 -> class_idx=3.
   - Rerun with N24x=0x801 -> class_idx=24, max_val=0x801.
4. All zero plus snapshot isolation:
   - all inputs 0, start -> done with class_idx=0, max_val=0, all_zero=1.
   - Repeat, driving N5x=0xFFFF one cycle after start -> result unchanged (all_zero=1).
5. Busy protection and back-to-back starts:
   - start pulses at edges k, k+4, k+10 -> exactly one done, after edge k+25.
   - start in the done cycle -> second done after 25 further edges.
6. Reset mid-operation: start, then reset=0 at edge k+12 -> no done pulse, outputs 0, state IDLE. A subsequent start completes normally with the correct result.

Source files
------------

// File: rtl/layer4_argmax.sv
// Argmax over the layer-4 fully-connected node outputs: snapshot on start,
// then a one-per-cycle scan that reports the winning class index and value.
module layer4_argmax #(
  parameter int unsigned NUM_IN = 25,
  parameter int unsigned IDX_W  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [32*NUM_IN-1:0]    Nx_flat,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        class_idx,
  output logic [31:0]             max_val,
  output logic                    all_zero
);

  localparam int unsigned VAL_W = 32;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;

  logic [IDX_W-1:0]   cnt;
  logic [VAL_W-1:0]   best_val;
  logic [IDX_W-1:0]   best_idx;
  logic [VAL_W-1:0]   snap [NUM_IN];

  logic               last_c;
  logic               take_c;
  logic [VAL_W-1:0]   cand_val_c;
  logic [IDX_W-1:0]   cand_idx_c;

  // Next state plus the running compare; strict '>' keeps the lowest index on ties
  always_comb begin
    state_nxt  = state;
    last_c     = (cnt == LAST_IDX);
    take_c     = (snap[cnt] > best_val);
    cand_val_c = best_val;
    cand_idx_c = best_idx;
    if (take_c) begin
      cand_val_c = snap[cnt];
      cand_idx_c = cnt;
    end
    case (state)
      IDLE: if (start) state_nxt = SCAN;
      SCAN: if (last_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath: snapshot bank, running best, and registered result outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      class_idx <= '0;
      max_val   <= '0;
      all_zero  <= 1'b0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        snap[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
              snap[i] <= Nx_flat[VAL_W*i +: VAL_W];
            end
            cnt      <= '0;
            best_val <= '0;
            best_idx <= '0;
            busy     <= 1'b1;
          end
        end
        SCAN: begin
          best_val <= cand_val_c;
          best_idx <= cand_idx_c;
          cnt      <= cnt + IDX_W'(1);
          // Final element goes straight to the outputs, no extra cycle
          if (last_c) begin
            class_idx <= cand_idx_c;
            max_val   <= cand_val_c;
            all_zero  <= (cand_val_c == '0);
            done      <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_layer4_argmax.sv
// Self-checking bench for layer4_argmax: directed sequence plus random vectors
// compared against a max-then-first-index reference model.
module tb_layer4_argmax;

  localparam int unsigned NUM = 25;
  localparam int unsigned IW  = 5;

  logic              clk;
  logic              reset;
  logic              start;
  logic [32*NUM-1:0] Nx_flat;
  logic              busy;
  logic              done;
  logic [IW-1:0]     class_idx;
  logic [31:0]       max_val;
  logic              all_zero;

  int errors = 0;
  int checks = 0;

  logic [31:0] vals  [NUM];
  logic [31:0] snapv [NUM];

  layer4_argmax #(.NUM_IN(NUM), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .Nx_flat(Nx_flat),
    .busy(busy), .done(done), .class_idx(class_idx),
    .max_val(max_val), .all_zero(all_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_idx"},   32'(class_idx), 32'd0);
    chk({tag, "_max"},   max_val, 32'd0);
    chk({tag, "_zero"},  32'(all_zero), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vals();
    for (int i = 0; i < NUM; i++) Nx_flat[32*i +: 32] = vals[i];
  endtask

  // mode 0: Q13 16-bit, 1: tiny range (many ties), 2: full 32-bit
  task automatic rand_vals(input int mode);
    for (int i = 0; i < NUM; i++) begin
      case (mode)
        0: vals[i] = 32'($urandom_range(0, 16'hFFFF));
        1: vals[i] = 32'($urandom_range(0, 3));
        default: vals[i] = $urandom;
      endcase
    end
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < NUM; i++) vals[i] = v;
  endtask

  // Pulse start for one edge with current vals; the snapshot is what the DUT must use
  task automatic do_start();
    drive_vals();
    for (int i = 0; i < NUM; i++) snapv[i] = vals[i];
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  // Reference: find the maximum, then the first index holding it
  task automatic model(output int idx, output logic [31:0] mx);
    mx = 32'd0;
    foreach (snapv[i]) if (snapv[i] > mx) mx = snapv[i];
    idx = 0;
    for (int i = NUM - 1; i >= 0; i--) if (snapv[i] == mx) idx = i;
  endtask

  // Wait (bounded) for done; busy must stay high on every cycle before it
  task automatic wait_done(input string tag, output int n);
    int bad;
    bad = 0;
    n = -1;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (done) begin
        n = c;
        break;
      end
      if (busy !== 1'b1) bad++;
    end
    chk({tag, "_busy_span"}, 32'(bad), 32'd0);
    chk({tag, "_latency"}, 32'(n), 32'(NUM));
  endtask

  task automatic check_result(input string tag);
    int          eidx;
    logic [31:0] emax;
    model(eidx, emax);
    chk({tag, "_idx"},  32'(class_idx), 32'(eidx));
    chk({tag, "_max"},  max_val, emax);
    chk({tag, "_zero"}, 32'(all_zero), 32'(emax == 32'd0));
    chk({tag, "_busy_off"}, 32'(busy), 32'd0);
  endtask

  task automatic check_hold(input string tag);
    int          eidx;
    logic [31:0] emax;
    model(eidx, emax);
    step();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold_idx"}, 32'(class_idx), 32'(eidx));
    chk({tag, "_hold_max"}, max_val, emax);
  endtask

  task automatic run_scan(input string tag);
    int n;
    do_start();
    wait_done(tag, n);
    check_result(tag);
    check_hold(tag);
  endtask

  initial begin
    int n;
    int dcount;
    int dn;
    reset   = 1'b0;
    start   = 1'b0;
    Nx_flat = '0;

    // 1: reset dominates start
    for (int c = 0; c < 3; c++) begin
      rand_vals(0);
      drive_vals();
      start = 1'b1;
      step();
      chk_zero_outputs("rst_hold");
    end
    start = 1'b0;
    reset = 1'b1;
    dcount = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      if (done) dcount++;
    end
    chk("idle_no_done", 32'(dcount), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // 2: single maximum
    for (int i = 0; i < NUM; i++) vals[i] = 32'($urandom_range(0, 32'h100));
    vals[7] = 32'h0000_1F00;
    run_scan("single_max");
    chk("single_max_idx7", 32'(class_idx), 32'd7);

    // 3: tie resolves to lowest index, then last element wins
    set_all(32'd0);
    vals[3]  = 32'h800;
    vals[20] = 32'h800;
    run_scan("tie");
    chk("tie_idx3", 32'(class_idx), 32'd3);
    vals[24] = 32'h801;
    run_scan("last_elem");
    chk("last_idx24", 32'(class_idx), 32'd24);

    // 4: all zero, and inputs changed after the snapshot edge are ignored
    set_all(32'd0);
    run_scan("all_zero");
    chk("all_zero_flag", 32'(all_zero), 32'd1);
    do_start();
    Nx_flat[32*5 +: 32] = 32'h0000_FFFF;
    wait_done("snap_iso", n);
    check_result("snap_iso");
    chk("snap_iso_flag", 32'(all_zero), 32'd1);
    Nx_flat = '0;

    // 5: restarts during busy are ignored; start in the done cycle is accepted
    rand_vals(0);
    do_start();
    dn = -1;
    dcount = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 4 || c == 10) begin
        rand_vals(0);
        drive_vals();
        start = 1'b1;
      end
      step();
      start = 1'b0;
      if (done) begin
        dcount++;
        dn = c;
        break;
      end
    end
    chk("b2b_latency", 32'(dn), 32'(NUM));
    check_result("b2b_first");
    rand_vals(0);
    do_start();
    wait_done("b2b_second", n);
    check_result("b2b_second");
    check_hold("b2b_second");

    // 6: reset mid-scan aborts with no done, then a fresh scan completes
    rand_vals(0);
    do_start();
    dcount = 0;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (done) dcount++;
    end
    reset = 1'b0;
    step();
    chk_zero_outputs("mid_rst");
    reset = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      if (done) dcount++;
    end
    chk("mid_rst_no_done", 32'(dcount), 32'd0);
    chk("mid_rst_idle_busy", 32'(busy), 32'd0);
    rand_vals(0);
    run_scan("post_rst");

    // Random vectors: Q13 values, heavy ties, and full-width upper bits
    for (int r = 0; r < 9; r++) begin
      rand_vals(r % 3);
      run_scan("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
